// File: rtl/serial_add_seq_if.sv
// Bus between the serial adder sequencer, its requester and the external half adder.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface serial_add_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             ha_a;
  logic             ha_b;
  logic             ha_sum;
  logic             ha_cout;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   result;

  modport slave (
    input  start, a_in, b_in, ha_sum, ha_cout,
    output ha_a, ha_b, busy, done, result
  );

  modport master (
    output start, a_in, b_in, ha_sum, ha_cout,
    input  ha_a, ha_b, busy, done, result
  );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial adder built around an external single-bit half adder.
// Operands stream LSB first; a local carry register completes each full-adder step.
module serial_add_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_seq_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   result_q, result_d;

  logic             sum_bit;
  logic             carry_next;

  // Second half-adder stage folds the stored carry into the external half adder output.
  assign sum_bit    = bus.ha_sum ^ carry_q;
  assign carry_next = bus.ha_cout | (bus.ha_sum & carry_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          carry_d = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_next;
        // Sum bits enter at the MSB so bit 0 ends up lowest after WIDTH shifts.
        acc_d   = (acc_q >> 1) | {sum_bit, {(WIDTH-1){1'b0}}};
        if (cnt_q == CntLast) begin
          result_d = {carry_next, sum_bit, acc_q[WIDTH-1:1]};
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

  assign bus.ha_a   = (state_q == StShift) & a_q[0];
  assign bus.ha_b   = (state_q == StShift) & b_q[0];
  assign bus.busy   = (state_q == StShift);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: directed corner sums, random sums against
// integer addition, start-ignore rules, back-to-back throughput and reset abort.
module tb_serial_add_seq;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_add_seq_if #(.WIDTH(W)) sa_if ();

  // Behavioural half adder sitting outside the sequencer.
  assign sa_if.ha_sum  = sa_if.ha_a ^ sa_if.ha_b;
  assign sa_if.ha_cout = sa_if.ha_a & sa_if.ha_b;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sa_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    sa_if.start = 1'b0;
    sa_if.a_in  = '0;
    sa_if.b_in  = '0;
    #1;
    checks++;
    if (sa_if.busy !== 1'b0 || sa_if.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b want 0 0", sa_if.busy, sa_if.done);
    end
    checks++;
    if (sa_if.result !== '0 || sa_if.ha_a !== 1'b0 || sa_if.ha_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_data result=%h ha_a=%b ha_b=%b want 0", sa_if.result, sa_if.ha_a,
               sa_if.ha_b);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One full addition from IDLE; checks serial bit order, busy window, done pulse and sum.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W:0] exp;
    exp = {1'b0, a} + {1'b0, b};
    sa_if.a_in  = a;
    sa_if.b_in  = b;
    sa_if.start = 1'b1;
    tick();
    sa_if.start = 1'b0;
    for (int k = 0; k < int'(W); k++) begin
      checks++;
      if (sa_if.busy !== 1'b1 || sa_if.done !== 1'b0 || sa_if.ha_a !== a[k] ||
          sa_if.ha_b !== b[k]) begin
        failures++;
        $display("FAIL %s shift%0d busy=%b done=%b ha_a=%b ha_b=%b want 1 0 %b %b", tag, k,
                 sa_if.busy, sa_if.done, sa_if.ha_a, sa_if.ha_b, a[k], b[k]);
      end
      tick();
    end
    checks++;
    if (sa_if.done !== 1'b1 || sa_if.busy !== 1'b0 || sa_if.result !== exp) begin
      failures++;
      $display("FAIL %s done done=%b busy=%b result=%h want 1 0 %h", tag, sa_if.done,
               sa_if.busy, sa_if.result, exp);
    end
    tick();
    checks++;
    if (sa_if.done !== 1'b0 || sa_if.result !== exp || sa_if.ha_a !== 1'b0) begin
      failures++;
      $display("FAIL %s after done=%b result=%h ha_a=%b want 0 %h 0", tag, sa_if.done,
               sa_if.result, sa_if.ha_a, exp);
    end
  endtask

  task automatic test_directed();
    do_add(8'h00, 8'h00, "zero");
    do_add(8'hFF, 8'h01, "ripple");
    do_add(8'hA5, 8'h5A, "nocarry");
    do_add(8'hFF, 8'hFF, "max");
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      do_add(a, b, "rand");
    end
  endtask

  task automatic test_ignore_start();
    int         done_seen;
    int         busy_seen;
    logic [W:0] exp;
    exp = {1'b0, 8'h0F} + {1'b0, 8'h01};
    done_seen = 0;
    busy_seen = 0;
    sa_if.a_in  = 8'h0F;
    sa_if.b_in  = 8'h01;
    sa_if.start = 1'b1;
    tick();
    sa_if.start = 1'b0;
    for (int i = 0; i < int'(W) + 12; i++) begin
      if (sa_if.done === 1'b1) done_seen++;
      if (i == 3) begin
        sa_if.start = 1'b1;
        sa_if.a_in  = 8'hAA;
        sa_if.b_in  = 8'h55;
      end else if (i == int'(W)) begin
        sa_if.start = 1'b1;
        sa_if.a_in  = 8'h33;
        sa_if.b_in  = 8'h44;
      end else begin
        sa_if.start = 1'b0;
      end
      if (i > int'(W) && sa_if.busy === 1'b1) busy_seen++;
      tick();
    end
    checks++;
    if (done_seen != 1 || busy_seen != 0) begin
      failures++;
      $display("FAIL ignore_start done_pulses=%0d late_busy=%0d want 1 0", done_seen,
               busy_seen);
    end
    checks++;
    if (sa_if.result !== exp) begin
      failures++;
      $display("FAIL ignore_result result=%h want %h", sa_if.result, exp);
    end
  endtask

  task automatic test_back_to_back();
    int         done_idx[$];
    logic [W:0] done_res[$];
    logic [W:0] exp1;
    logic [W:0] exp2;
    exp1 = {1'b0, 8'h80} + {1'b0, 8'h80};
    exp2 = {1'b0, 8'h01} + {1'b0, 8'h02};
    sa_if.a_in  = 8'h80;
    sa_if.b_in  = 8'h80;
    sa_if.start = 1'b1;
    tick();
    sa_if.a_in = 8'h01;
    sa_if.b_in = 8'h02;
    for (int i = 0; i < 2 * int'(W) + 6; i++) begin
      if (sa_if.done === 1'b1) begin
        done_idx.push_back(i);
        done_res.push_back(sa_if.result);
      end
      if (i == int'(W) + 2) begin
        checks++;
        if (sa_if.busy !== 1'b1) begin
          failures++;
          $display("FAIL b2b_accept busy=%b want 1", sa_if.busy);
        end
        sa_if.start = 1'b0;
      end
      tick();
    end
    checks++;
    if (done_idx.size() != 2) begin
      failures++;
      $display("FAIL b2b_count done_pulses=%0d want 2", done_idx.size());
    end else begin
      checks++;
      if (done_idx[0] != int'(W) || done_idx[1] != 2 * int'(W) + 2) begin
        failures++;
        $display("FAIL b2b_spacing done_at=%0d,%0d want %0d,%0d", done_idx[0], done_idx[1],
                 W, 2 * W + 2);
      end
      checks++;
      if (done_res[0] !== exp1 || done_res[1] !== exp2) begin
        failures++;
        $display("FAIL b2b_result got=%h,%h want %h,%h", done_res[0], done_res[1], exp1, exp2);
      end
    end
  endtask

  task automatic test_reset_abort();
    int done_seen;
    done_seen = 0;
    do_add(8'h12, 8'h34, "pre_abort");
    sa_if.a_in  = 8'hFF;
    sa_if.b_in  = 8'hFF;
    sa_if.start = 1'b1;
    tick();
    sa_if.start = 1'b0;
    repeat (4) tick();
    checks++;
    if (sa_if.busy !== 1'b1 || sa_if.ha_a !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre busy=%b ha_a=%b want 1 1", sa_if.busy, sa_if.ha_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sa_if.busy !== 1'b0 || sa_if.result !== '0 || sa_if.ha_a !== 1'b0 ||
        sa_if.ha_b !== 1'b0) begin
      failures++;
      $display("FAIL abort_now busy=%b result=%h ha_a=%b ha_b=%b want 0 0 0 0", sa_if.busy,
               sa_if.result, sa_if.ha_a, sa_if.ha_b);
    end
    for (int i = 0; i < int'(W) + 4; i++) begin
      if (sa_if.done === 1'b1) done_seen++;
      if (i == 3) rst_n = 1'b1;
      tick();
    end
    checks++;
    if (done_seen != 0 || sa_if.result !== '0) begin
      failures++;
      $display("FAIL abort_nodone done_pulses=%0d result=%h want 0 0", done_seen,
               sa_if.result);
    end
    do_add(8'h01, 8'h01, "post_abort");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
